// File: rtl/cpu_board_pkg.sv
// Shared constants for the CPU board front end: debounce states, display selects,
// seven-segment lookup and anode helpers.
package cpu_board_pkg;

  typedef logic [1:0] deb_state_t;

  localparam deb_state_t ST_REL        = 2'd0;
  localparam deb_state_t ST_PRESS_WAIT = 2'd1;
  localparam deb_state_t ST_PRESSED    = 2'd2;
  localparam deb_state_t ST_REL_WAIT   = 2'd3;

  localparam logic [1:0] SEL_PC  = 2'b00;
  localparam logic [1:0] SEL_RS  = 2'b01;
  localparam logic [1:0] SEL_RT  = 2'b10;
  localparam logic [1:0] SEL_RES = 2'b11;

  localparam logic [3:0] AN_OFF  = 4'b1111;
  localparam logic [7:0] SEG_OFF = 8'hFF;

  // Active-low {dp,g,f,e,d,c,b,a}, decimal point off.
  localparam logic [7:0] SEG_HEX [16] = '{
    8'hC0, 8'hF9, 8'hA4, 8'hB0, 8'h99, 8'h92, 8'h82, 8'hF8,
    8'h80, 8'h90, 8'h88, 8'h83, 8'hC6, 8'hA1, 8'h86, 8'h8E
  };

  function automatic logic [3:0] an_onehot_low(input logic [1:0] idx);
    return ~(4'b0001 << idx);
  endfunction

endpackage

// File: rtl/cpu_board_display_if.sv
// CPU debug bus into the display front end, plus the debounce FSM state coming back out.
// No handshake: every field is a level sampled when a display digit is loaded.
interface cpu_board_display_if;
  logic [7:0] cur_pc;
  logic [7:0] next_pc;
  logic [4:0] rs_addr;
  logic [4:0] rt_addr;
  logic [7:0] rd1;
  logic [7:0] rd2;
  logic [7:0] alu_result;
  logic [7:0] mem_out;
  logic [1:0] deb_state;

  modport master (
    output cur_pc, next_pc, rs_addr, rt_addr, rd1, rd2, alu_result, mem_out,
    input  deb_state
  );

  modport slave (
    input  cur_pc, next_pc, rs_addr, rt_addr, rd1, rd2, alu_result, mem_out,
    output deb_state
  );
endinterface

// File: rtl/cpu_board_display_debounce.sv
// button_debounce: 2-FF synchroniser feeding a press/release debounce FSM; level is high
// while the button is considered pressed.
module button_debounce
  import cpu_board_pkg::*;
#(
  parameter int DEBOUNCE_CYCLES = 1_000_000
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       btn_raw,
  output logic       level,
  output deb_state_t state
);

  localparam int CW = (DEBOUNCE_CYCLES > 1) ? $clog2(DEBOUNCE_CYCLES) : 1;
  localparam logic [CW-1:0] CNT_LAST = CW'(DEBOUNCE_CYCLES - 1);

  logic          meta_q, meta_d;
  logic          sync_q, sync_d;
  deb_state_t    state_q, state_d;
  logic [CW-1:0] cnt_q, cnt_d;

  always_comb begin
    meta_d  = btn_raw;
    sync_d  = meta_q;
    state_d = state_q;
    cnt_d   = cnt_q;
    case (state_q)
      ST_REL:        if (sync_q) state_d = ST_PRESS_WAIT;
      ST_PRESS_WAIT: begin
        if (!sync_q)                state_d = ST_REL;
        else if (cnt_q == CNT_LAST) state_d = ST_PRESSED;
        else                        cnt_d   = cnt_q + 1'b1;
      end
      ST_PRESSED:    if (!sync_q) state_d = ST_REL_WAIT;
      default: begin
        if (sync_q)                 state_d = ST_PRESSED;
        else if (cnt_q == CNT_LAST) state_d = ST_REL;
        else                        cnt_d   = cnt_q + 1'b1;
      end
    endcase
    // Every state change restarts the stability window.
    if (state_d != state_q) cnt_d = '0;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      meta_q  <= 1'b0;
      sync_q  <= 1'b0;
      state_q <= ST_REL;
      cnt_q   <= '0;
    end else begin
      meta_q  <= meta_d;
      sync_q  <= sync_d;
      state_q <= state_d;
      cnt_q   <= cnt_d;
    end
  end

  assign level = (state_q == ST_PRESSED) || (state_q == ST_REL_WAIT);
  assign state = state_q;

endmodule

// File: rtl/cpu_board_display.sv
// Board front end for single_cpu: debounced step clock plus a 4-digit scanned hex display.
// Optional free-running step clock when AUTO_STEP_EN is defined (adds the auto_run port).
module cpu_board_display
  import cpu_board_pkg::*;
#(
  parameter int DEBOUNCE_CYCLES = 1_000_000,
  parameter int SCAN_DIV        = 100_000,
  parameter int AUTO_DIV        = 25_000_000
) (
  input  logic                 CLK,
  input  logic                 Reset,
  input  logic                 btn_step,
  input  logic [1:0]           sw_sel,
`ifdef AUTO_STEP_EN
  input  logic                 auto_run,
`endif
  cpu_board_display_if.slave   dbg,
  output logic                 cpu_clk,
  output logic [3:0]           an,
  output logic [7:0]           seg
);

  logic       deb_level;
  deb_state_t deb_state;

  button_debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_debounce (
    .clk     (CLK),
    .rst     (Reset),
    .btn_raw (btn_step),
    .level   (deb_level),
    .state   (deb_state)
  );

  assign dbg.deb_state = deb_state;

  logic cpu_clk_q, cpu_clk_d;

`ifdef AUTO_STEP_EN
  localparam int AW = (AUTO_DIV > 1) ? $clog2(AUTO_DIV) : 1;
  localparam logic [AW-1:0] AUTO_LAST = AW'(AUTO_DIV - 1);

  logic [AW-1:0] auto_cnt_q, auto_cnt_d;
  logic          auto_mode_q, auto_mode_d;
  logic          auto_clk_q, auto_clk_d;
  logic          auto_wrap;

  // Mode changes only on a divider wrap, so leaving auto mode parks cpu_clk low cleanly.
  always_comb begin
    auto_wrap   = (auto_cnt_q == AUTO_LAST);
    auto_cnt_d  = auto_wrap ? '0 : auto_cnt_q + 1'b1;
    auto_mode_d = auto_mode_q;
    auto_clk_d  = auto_clk_q;
    if (auto_wrap) begin
      auto_mode_d = auto_run;
      auto_clk_d  = auto_run ? ~auto_clk_q : 1'b0;
    end
    cpu_clk_d = auto_mode_d ? auto_clk_d : deb_level;
  end

  always_ff @(posedge CLK or posedge Reset) begin
    if (Reset) begin
      auto_cnt_q  <= '0;
      auto_mode_q <= 1'b0;
      auto_clk_q  <= 1'b0;
    end else begin
      auto_cnt_q  <= auto_cnt_d;
      auto_mode_q <= auto_mode_d;
      auto_clk_q  <= auto_clk_d;
    end
  end
`else
  always_comb cpu_clk_d = deb_level;
`endif

  localparam int PW = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;
  localparam logic [PW-1:0] SCAN_LAST = PW'(SCAN_DIV - 1);

  logic [PW-1:0] presc_q, presc_d;
  logic [1:0]    idx_q, idx_d;
  logic          load_q, load_d;
  logic [3:0]    an_q, an_d;
  logic [7:0]    seg_q, seg_d;
  logic [15:0]   disp_word;
  logic [3:0]    nib;

  always_comb begin
    case (sw_sel)
      SEL_PC:  disp_word = {dbg.cur_pc, dbg.next_pc};
      SEL_RS:  disp_word = {3'b000, dbg.rs_addr, dbg.rd1};
      SEL_RT:  disp_word = {3'b000, dbg.rt_addr, dbg.rd2};
      default: disp_word = {dbg.alu_result, dbg.mem_out};
    endcase
  end

  // load_q marks the cycle after an index step; the new digit is latched then.
  always_comb begin
    load_d  = (presc_q == SCAN_LAST);
    presc_d = load_d ? '0 : presc_q + 1'b1;
    idx_d   = load_d ? idx_q + 2'd1 : idx_q;
    nib     = disp_word[{idx_q, 2'b00} +: 4];
    an_d    = an_q;
    seg_d   = seg_q;
    if (load_q) begin
      an_d  = an_onehot_low(idx_q);
      seg_d = SEG_HEX[nib];
    end
  end

  always_ff @(posedge CLK or posedge Reset) begin
    if (Reset) begin
      presc_q   <= '0;
      idx_q     <= 2'd0;
      load_q    <= 1'b0;
      an_q      <= AN_OFF;
      seg_q     <= SEG_OFF;
      cpu_clk_q <= 1'b0;
    end else begin
      presc_q   <= presc_d;
      idx_q     <= idx_d;
      load_q    <= load_d;
      an_q      <= an_d;
      seg_q     <= seg_d;
      cpu_clk_q <= cpu_clk_d;
    end
  end

  assign cpu_clk = cpu_clk_q;
  assign an      = an_q;
  assign seg     = seg_q;

endmodule

// File: tb/tb_cpu_board_display.sv
// Scoreboard bench for cpu_board_display: step-clock edges and display digit loads are
// predicted from the button/display rules and checked by an independent monitor.
module tb_cpu_board_display;

  localparam int DEB  = 4;
  localparam int SCAN = 2;
  localparam int ADIV = 3;

  // ---------------- clock / reset ----------------
  logic       CLK = 1'b0;
  logic       Reset;
  logic       btn_step;
  logic [1:0] sw_sel;
  logic       cpu_clk;
  logic [3:0] an;
  logic [7:0] seg;
`ifdef AUTO_STEP_EN
  logic       auto_run;
`endif

  cpu_board_display_if dbg();

  cpu_board_display #(
    .DEBOUNCE_CYCLES (DEB),
    .SCAN_DIV        (SCAN),
    .AUTO_DIV        (ADIV)
  ) dut (
    .CLK      (CLK),
    .Reset    (Reset),
    .btn_step (btn_step),
    .sw_sel   (sw_sel),
`ifdef AUTO_STEP_EN
    .auto_run (auto_run),
`endif
    .dbg      (dbg),
    .cpu_clk  (cpu_clk),
    .an       (an),
    .seg      (seg)
  );

  always #5 CLK = ~CLK;

  int unsigned cyc = 0;
  always @(posedge CLK) cyc <= cyc + 1;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached, required finish");
    $fatal(1);
  end

  // ---------------- scoreboard ----------------
  int total = 0;
  int bad   = 0;
  bit disp_en    = 1'b0;
  bit clk_chk_en = 1'b1;

  logic [31:0] exp_clk_q[$];   // {level, cycle of the change}
  logic [11:0] exp_disp_q[$];  // {an, seg}

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h required %0h", name, act, exp);
    end
  endtask

  function automatic logic [7:0] hex_of(input logic [3:0] v);
    case (v)
      4'h0: return 8'hC0;  4'h1: return 8'hF9;  4'h2: return 8'hA4;  4'h3: return 8'hB0;
      4'h4: return 8'h99;  4'h5: return 8'h92;  4'h6: return 8'h82;  4'h7: return 8'hF8;
      4'h8: return 8'h80;  4'h9: return 8'h90;  4'hA: return 8'h88;  4'hB: return 8'h83;
      4'hC: return 8'hC6;  4'hD: return 8'hA1;  4'hE: return 8'h86;  default: return 8'h8E;
    endcase
  endfunction

  function automatic logic [15:0] model_word();
    case (sw_sel)
      2'b00:   return {dbg.cur_pc, dbg.next_pc};
      2'b01:   return {3'b000, dbg.rs_addr, dbg.rd1};
      2'b10:   return {3'b000, dbg.rt_addr, dbg.rd2};
      default: return {dbg.alu_result, dbg.mem_out};
    endcase
  endfunction

  // Digits appear in rising index order; index 3 is the leftmost digit (an[3]).
  task automatic push_digits(input logic [15:0] w, input int first, input int n);
    logic [3:0] a;
    logic [3:0] nib;
    int k;
    for (int i = 0; i < n; i++) begin
      k = (first + i) % 4;
      a = 4'b1111;
      a[k] = 1'b0;
      nib = 4'(w >> (4 * k));
      exp_disp_q.push_back({a, hex_of(nib)});
    end
  endtask

  // ---------------- monitor ----------------
  initial begin
    logic        prev_clk;
    logic [3:0]  prev_an;
    int unsigned last_load;
    bit          load_seen;
    logic [31:0] ec;
    logic [11:0] ed;
    prev_clk  = 1'b0;
    prev_an   = 4'hF;
    last_load = 0;
    load_seen = 1'b0;
    forever begin
      @(negedge CLK);
      if (!disp_en) load_seen = 1'b0;
      if (Reset !== 1'b1) begin
        if (clk_chk_en && cpu_clk !== prev_clk) begin
          if (exp_clk_q.size() == 0) begin
            total++;
            bad++;
            $display("FAIL cpu_clk_edge: got level %0b at cycle %0d, required no edge", cpu_clk, cyc);
          end else begin
            ec = exp_clk_q.pop_front();
            check("cpu_clk_edge", {cpu_clk, cyc[30:0]}, ec);
          end
        end
        if (disp_en && an !== prev_an && an !== 4'hF) begin
          if (exp_disp_q.size() == 0) begin
            total++;
            bad++;
            $display("FAIL disp_load: got an=%b seg=%h, required no load", an, seg);
          end else begin
            ed = exp_disp_q.pop_front();
            check("disp_an", 32'(an), 32'(ed[11:8]));
            check("disp_seg", 32'(seg), 32'(ed[7:0]));
          end
          if (load_seen) check("scan_period", cyc - last_load, SCAN);
          load_seen = 1'b1;
          last_load = cyc;
        end
      end
      prev_clk = cpu_clk;
      prev_an  = an;
    end
  end

  // ---------------- driver tasks ----------------
  task automatic drain(input int budget);
    int n;
    n = 0;
    while ((exp_clk_q.size() != 0 || exp_disp_q.size() != 0) && n < budget) begin
      @(negedge CLK);
      n++;
    end
    total++;
    if (exp_clk_q.size() != 0 || exp_disp_q.size() != 0) begin
      bad++;
      $display("FAIL drain: pending clk=%0d disp=%0d, required 0", exp_clk_q.size(), exp_disp_q.size());
      exp_clk_q.delete();
      exp_disp_q.delete();
    end
  endtask

  // A press is accepted once the synchronised level has been high for DEB+1 samples;
  // each accepted edge shows on cpu_clk 2 (sync) + DEB + 1 cycles after the input edge.
  task automatic press(input int hold, input int gap);
    int unsigned pe, re;
    @(negedge CLK);
    pe = cyc + 1;
    if (hold >= DEB + 1) exp_clk_q.push_back({1'b1, 31'(pe + DEB + 3)});
    btn_step = 1'b1;
    repeat (hold) @(negedge CLK);
    re = cyc + 1;
    if (hold >= DEB + 1) exp_clk_q.push_back({1'b0, 31'(re + DEB + 3)});
    btn_step = 1'b0;
    repeat (gap) @(negedge CLK);
  endtask

  task automatic randomize_bus();
    dbg.cur_pc     = 8'($urandom);
    dbg.next_pc    = 8'($urandom);
    dbg.rs_addr    = 5'($urandom);
    dbg.rt_addr    = 5'($urandom);
    dbg.rd1        = 8'($urandom);
    dbg.rd2        = 8'($urandom);
    dbg.alu_result = 8'($urandom);
    dbg.mem_out    = 8'($urandom);
  endtask

`ifdef AUTO_STEP_EN
  task automatic wait_rise(output int unsigned t);
    logic p;
    int n;
    p = cpu_clk;
    n = 0;
    t = 0;
    while (n < 20) begin
      @(negedge CLK);
      n++;
      if (cpu_clk && !p) begin
        t = cyc;
        break;
      end
      p = cpu_clk;
    end
  endtask
`endif

  // ---------------- stimulus ----------------
  initial begin
    int n;
    Reset    = 1'b1;
    btn_step = 1'b0;
    sw_sel   = 2'b00;
    randomize_bus();
`ifdef AUTO_STEP_EN
    auto_run = 1'b0;
`endif
    repeat (3) @(negedge CLK);
    check("reset_cpu_clk", 32'(cpu_clk), 32'd0);
    check("reset_an", 32'(an), 32'hF);
    check("reset_seg", 32'(seg), 32'hFF);
    check("reset_state", 32'(dbg.deb_state), 32'd0);

    // Display: PC view, two full scans.
    sw_sel      = 2'b00;
    dbg.cur_pc  = 8'h04;
    dbg.next_pc = 8'h08;
    push_digits(model_word(), 1, 8);
    disp_en = 1'b1;
    Reset   = 1'b0;
    drain(40);
    disp_en = 1'b0;

    // Display: rs view, then switch to result view mid-scan.
    @(negedge CLK);
    Reset = 1'b1;
    sw_sel      = 2'b01;
    dbg.rs_addr = 5'h1F;
    dbg.rd1     = 8'hAF;
    push_digits(model_word(), 1, 4);
    disp_en = 1'b1;
    @(negedge CLK);
    Reset = 1'b0;
    n = 0;
    while (exp_disp_q.size() != 0 && n < 40) begin
      @(posedge CLK);
      #1;
      n++;
    end
    check("mid_scan_reach", exp_disp_q.size(), 0);
    sw_sel         = 2'b11;
    dbg.alu_result = 8'($urandom);
    dbg.mem_out    = 8'($urandom);
    push_digits(model_word(), 1, 4);
    drain(40);
    disp_en = 1'b0;

    // Display: random selects and bus values.
    for (int r = 0; r < 4; r++) begin
      @(negedge CLK);
      Reset  = 1'b1;
      sw_sel = 2'($urandom_range(0, 3));
      randomize_bus();
      push_digits(model_word(), 1, 4);
      disp_en = 1'b1;
      @(negedge CLK);
      Reset = 1'b0;
      drain(40);
      disp_en = 1'b0;
    end

    // Step button: clean press, boundary holds, bounce, random presses.
    press(20, 20);
    press(DEB, 8);
    press(DEB + 1, 8);
    press(1, 0);
    press(1, 10);
    for (int r = 0; r < 12; r++) press($urandom_range(1, 16), $urandom_range(6, 14));
    drain(60);

    // Reset while the debouncer is still qualifying a press.
    @(negedge CLK);
    btn_step = 1'b1;
    repeat (4) @(negedge CLK);
    check("pw_state", 32'(dbg.deb_state), 32'd1);
    #2;
    Reset = 1'b1;
    #1;
    check("midpress_cpu_clk", 32'(cpu_clk), 32'd0);
    check("midpress_an", 32'(an), 32'hF);
    check("midpress_seg", 32'(seg), 32'hFF);
    check("midpress_state", 32'(dbg.deb_state), 32'd0);
    btn_step = 1'b0;
    repeat (2) @(negedge CLK);
    Reset = 1'b0;
    repeat (15) @(negedge CLK);

`ifdef AUTO_STEP_EN
    begin
      int unsigned t1, t2;
      clk_chk_en = 1'b0;
      btn_step   = 1'b1;
      auto_run   = 1'b1;
      wait_rise(t1);
      for (int r = 0; r < 3; r++) begin
        wait_rise(t2);
        check("auto_period", t2 - t1, 2 * ADIV);
        t1 = t2;
      end
      auto_run = 1'b0;
      btn_step = 1'b0;
      repeat (14) @(negedge CLK);
      check("auto_off_low", 32'(cpu_clk), 32'd0);
      clk_chk_en = 1'b1;
      press(10, 10);
    end
`endif

    drain(60);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
